// File: rtl/ex_div.sv
// rtl/ex_div.sv - multi-cycle 32-bit signed/unsigned radix-2 restoring divider with EX stall request
module ex_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        annul_i,
    output logic        stallreq_for_ex,
    output logic        ready_o,
    output logic [63:0] result_o
);

    typedef enum logic [1:0] {IDLE, DIVZERO, RUN, DONE} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [64:0] work_q, work_d;
    logic [31:0] divisor_q, divisor_d;
    logic [31:0] dividend_q, dividend_d;
    logic        qsign_q, qsign_d;
    logic        rsign_q, rsign_d;
    logic        ready_q, ready_d;
    logic [63:0] result_q, result_d;

    logic        go;
    logic [31:0] abs_a, abs_b;
    logic [64:0] shifted, step;
    logic [33:0] trial;
    logic [31:0] quo_fix, rem_fix;

    // Dropping start mid-operation is treated exactly like an annul.
    assign go = start_i & ~annul_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            work_q     <= 65'd0;
            divisor_q  <= 32'd0;
            dividend_q <= 32'd0;
            qsign_q    <= 1'b0;
            rsign_q    <= 1'b0;
            ready_q    <= 1'b0;
            result_q   <= 64'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            divisor_q  <= divisor_d;
            dividend_q <= dividend_d;
            qsign_q    <= qsign_d;
            rsign_q    <= rsign_d;
            ready_q    <= ready_d;
            result_q   <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go) state_d = (opdata2_i == 32'd0) ? DIVZERO : RUN;
            DIVZERO: state_d = go ? DONE : IDLE;
            RUN: begin
                if (!go)                 state_d = IDLE;
                else if (cnt_q == 5'd31) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        abs_a   = (signed_i & opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
        abs_b   = (signed_i & opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
        shifted = {work_q[63:0], 1'b0};
        trial   = {1'b0, shifted[64:32]} - {2'b00, divisor_q};
        step    = trial[33] ? shifted : {trial[32:0], shifted[31:1], 1'b1};
        quo_fix = qsign_q ? (~step[31:0] + 32'd1) : step[31:0];
        rem_fix = rsign_q ? (~step[63:32] + 32'd1) : step[63:32];

        cnt_d      = cnt_q;
        work_d     = work_q;
        divisor_d  = divisor_q;
        dividend_d = dividend_q;
        qsign_d    = qsign_q;
        rsign_d    = rsign_q;
        ready_d    = 1'b0;
        result_d   = result_q;

        case (state_q)
            IDLE: begin
                if (go) begin
                    cnt_d      = 5'd0;
                    work_d     = {33'd0, abs_a};
                    divisor_d  = abs_b;
                    dividend_d = opdata1_i;
                    qsign_d    = signed_i & (opdata1_i[31] ^ opdata2_i[31]);
                    rsign_d    = signed_i & opdata1_i[31];
                end
            end
            DIVZERO: begin
                if (go) begin
                    ready_d  = 1'b1;
                    result_d = {dividend_q, 32'hFFFF_FFFF};
                end
            end
            RUN: begin
                work_d = step;
                cnt_d  = cnt_q + 5'd1;
                if (go && cnt_q == 5'd31) begin
                    ready_d  = 1'b1;
                    result_d = {rem_fix, quo_fix};
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        stallreq_for_ex = ~rst & go & (state_q != DONE);
        ready_o         = ready_q;
        result_o        = result_q;
    end

endmodule

// File: tb/tb_ex_div.sv
// tb/tb_ex_div.sv - directed self-checking bench for ex_div
module tb_ex_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic        stallreq_for_ex;
    logic        ready_o;
    logic [63:0] result_o;

    int n_checks = 0;
    int n_pass   = 0;

    ex_div dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start_i),
        .signed_i        (signed_i),
        .opdata1_i       (opdata1_i),
        .opdata2_i       (opdata2_i),
        .annul_i         (annul_i),
        .stallreq_for_ex (stallreq_for_ex),
        .ready_o         (ready_o),
        .result_o        (result_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        next_cycle();
        start_i = 1'b0;
        annul_i = 1'b0;
    endtask

    // Starts a divide in the next cycle, scrambles operands after the start
    // cycle, and checks latency, stall length and the result.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int lat);
        int stalls;
        int rcyc;
        stalls = 0;
        rcyc   = -1;
        next_cycle();
        start_i   = 1'b1;
        annul_i   = 1'b0;
        signed_i  = sgn;
        opdata1_i = a;
        opdata2_i = b;
        for (int c = 0; c <= 40 && rcyc < 0; c++) begin
            if (c > 0) begin
                next_cycle();
                opdata1_i = ~a;
                opdata2_i = b ^ 32'h5A5A_5A5A;
                signed_i  = ~sgn;
            end
            @(negedge clk);
            if (stallreq_for_ex) stalls++;
            if (ready_o) rcyc = c;
        end
        chk({tag, "_latency"}, 64'(rcyc), 64'(lat));
        chk({tag, "_stall_cycles"}, 64'(stalls), 64'(lat));
        chk({tag, "_result"}, result_o, exp);
    endtask

    initial begin
        int st;
        logic seen_ready;

        rst       = 1'b1;
        start_i   = 1'b0;
        signed_i  = 1'b0;
        opdata1_i = 32'd0;
        opdata2_i = 32'd0;
        annul_i   = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", 64'(ready_o), 64'd0);
        chk("reset_result", result_o, 64'd0);
        chk("reset_stall", 64'(stallreq_for_ex), 64'd0);

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        idle_cycle();
        @(negedge clk);
        chk("hold_ready", 64'(ready_o), 64'd0);
        chk("hold_result", result_o, {32'd2, 32'd14});

        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        idle_cycle();
        run_div("divu_fff9_2", 1'b0, 32'hFFFF_FFF9, 32'd2, {32'd1, 32'h7FFF_FFFC}, 33);
        idle_cycle();
        run_div("div_5_0", 1'b1, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 2);
        idle_cycle();
        run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
        idle_cycle();

        // Annul at T+10, restart at T+12.
        st = 0;
        seen_ready = 1'b0;
        next_cycle();
        start_i   = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) next_cycle();
            @(negedge clk);
            if (stallreq_for_ex) st++;
            if (ready_o) seen_ready = 1'b1;
        end
        chk("annul_pre_stall", 64'(st), 64'd10);
        next_cycle();
        annul_i = 1'b1;
        @(negedge clk);
        chk("annul_stall_drop", 64'(stallreq_for_ex), 64'd0);
        if (ready_o) seen_ready = 1'b1;
        next_cycle();
        annul_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        chk("annul_idle_stall", 64'(stallreq_for_ex), 64'd0);
        if (ready_o) seen_ready = 1'b1;
        chk("annul_no_ready", 64'(seen_ready), 64'd0);
        run_div("divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);
        idle_cycle();

        // Reset at T+20 of an in-flight divide.
        next_cycle();
        start_i   = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'd77;
        opdata2_i = 32'd5;
        for (int c = 1; c < 20; c++) next_cycle();
        @(negedge clk);
        chk("pre_rst_stall", 64'(stallreq_for_ex), 64'd1);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_stall", 64'(stallreq_for_ex), 64'd0);
        next_cycle();
        rst     = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(ready_o), 64'd0);
        chk("post_rst_result", result_o, 64'd0);
        chk("post_rst_stall", 64'(stallreq_for_ex), 64'd0);

        run_div("b2b_first", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 33);
        run_div("b2b_second", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 33);
        idle_cycle();
        @(negedge clk);
        chk("final_ready", 64'(ready_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
